sseg_scan_controller: RTL and testbench
=======================================

// Module: sseg_scan_controller
// PURPOSE
//  Time-multiplexed scan controller for a multi-digit common-anode seven-segment display.
//  It sequences one shared SSEG_Decoder across NUM_DIGITS digits: presents each digit's nibble on Num,
//  asserts that digit's anode, and inserts a blanking gap before each digit turns on to prevent ghosting.
//  New display values are double-buffered and applied only at frame boundaries, so a frame never shows mixed old/new data.
// PARAMETERS
//  NUM_DIGITS    4       number of digits scanned (>=1)
//  DIGIT_CYCLES  100000  clock cycles per digit slot (>=2)
//  BLANK_CYCLES  1000    leading cycles of each slot with all anodes off (1 <= BLANK_CYCLES < DIGIT_CYCLES)
// PORTS
//  clk          in   1             system clock, all logic on rising edge
//  reset        in   1             synchronous, active-high reset
//  load         in   1             capture digits/dp_mask/digit_en into pending buffer
//  digits       in   4*NUM_DIGITS  digit i nibble = digits[4i+3:4i]
//  dp_mask      in   NUM_DIGITS    1 = decimal point lit on digit i
//  digit_en     in   NUM_DIGITS    1 = digit i displayed; 0 = slot kept, anode held off
//  Num          out  4             nibble to SSEG_Decoder for current slot
//  Anode        out  NUM_DIGITS    active-low digit enables
//  DP_n         out  1             active-low decimal point
//  digit_idx    out  clog2(NUM_DIGITS) (min 1)  current slot index
//  frame_done   out  1             1-cycle pulse on last cycle of each frame
// BEHAVIOUR
//  - Registers: cnt (0..DIGIT_CYCLES-1), idx (0..NUM_DIGITS-1), pending{digits,dp,en}, pend_valid, shadow{digits,dp,en}.
//  - cnt increments every cycle; at DIGIT_CYCLES-1 wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
//  - Frame = NUM_DIGITS*DIGIT_CYCLES cycles, free-running, never stalls.
//  - Phase per slot: BLANK when cnt < BLANK_CYCLES, SHOW otherwise.
//  - Outputs are Moore: decoded from registered cnt/idx/shadow only, no combinational path from inputs.
//  - Num = shadow nibble[idx] for the whole slot (incl. BLANK, so decoder settles before anode on).
//  - Anode: all 1s in BLANK; in SHOW, Anode[idx] = ~shadow_en[idx], all others 1.
//  - DP_n: 1 in BLANK; in SHOW, ~(shadow_dp[idx] & shadow_en[idx]).
//  - digit_idx = idx. frame_done = (idx==NUM_DIGITS-1 && cnt==DIGIT_CYCLES-1).
//  - load: pending <= inputs, pend_valid <= 1; later load in same frame overwrites (last wins).
//  - At the frame_done clock edge: if load is high, shadow <= inputs directly; else if pend_valid, shadow <= pending.
//    pend_valid <= 0 in both cases. New values are visible from slot 0 of the next frame.
//  - Reset (any cycle, incl. mid-slot): cnt=0, idx=0, shadow/pending all 0, pend_valid=0 ->
//    Anode all 1s, Num=0, DP_n=1, digit_idx=0, frame_done=0. Display stays dark until the first load reaches shadow.
//  - load concurrent with reset: reset wins, load is dropped.
// TESTING (NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2)
//  1. reset 3 cycles, then idle 64 cycles -> Anode=4'b1111, Num=0, DP_n=1 throughout; frame_done pulses every 32 cycles.
//  2. load digits=16'h1234, en=4'b1111, dp=4'b0100 -> after next frame_done: slot0 cnt0-1 Anode=1111 Num=4;
//     cnt2-7 Anode=1110; slot1 Num=3 Anode=1101; slot2 Num=2 Anode=1011 DP_n=0; slot3 Num=1 Anode=0111.
//  3. digit_en=4'b0101 loaded -> Anode[1] and Anode[3] never 0 and DP_n stays 1 in slots 1/3; slot timing unchanged.
//  4. load 16'h1111 then 16'h2222 within one frame -> no frame ever shows 1; next frame shows 2 on all digits.
//  5. load 16'hABCD asserted exactly in the frame_done cycle -> next slot0 shows Num=D; no extra frame of delay.
//  6. reset asserted at idx=2, cnt=5 (SHOW) -> next cycle Anode=1111, Num=0, digit_idx=0; cnt restarts from 0.

Source files
------------

// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller: multiplexes one seven-segment decoder across NUM_DIGITS anodes with per-slot blanking
// and frame-boundary double buffering of the displayed value.
module sseg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(DIGIT_CYCLES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              Num,
  output logic [NUM_DIGITS-1:0]   Anode,
  output logic                    DP_n,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_done
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, pend_en_q, pend_en_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, sh_en_q, sh_en_d;
  logic pend_valid_q, pend_valid_d;
  logic last_cnt, last_idx, fd, blank;
  always_comb begin
    last_cnt = cnt_q == CW'(DIGIT_CYCLES - 1);
    last_idx = idx_q == IW'(NUM_DIGITS - 1);
    fd = last_cnt & last_idx;
    cnt_d = last_cnt ? '0 : cnt_q + CW'(1);
    idx_d = !last_cnt ? idx_q : last_idx ? '0 : idx_q + IW'(1);
    pend_dig_d = load ? digits : pend_dig_q;
    pend_dp_d = load ? dp_mask : pend_dp_q;
    pend_en_d = load ? digit_en : pend_en_q;
    pend_valid_d = fd ? 1'b0 : (load | pend_valid_q);
    // a load landing on the frame boundary bypasses the pending buffer
    sh_dig_d = (fd & load) ? digits : (fd & pend_valid_q) ? pend_dig_q : sh_dig_q;
    sh_dp_d = (fd & load) ? dp_mask : (fd & pend_valid_q) ? pend_dp_q : sh_dp_q;
    sh_en_d = (fd & load) ? digit_en : (fd & pend_valid_q) ? pend_en_q : sh_en_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      pend_dig_q <= '0;
      pend_dp_q <= '0;
      pend_en_q <= '0;
      pend_valid_q <= 1'b0;
      sh_dig_q <= '0;
      sh_dp_q <= '0;
      sh_en_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q <= pend_dp_d;
      pend_en_q <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q <= sh_dp_d;
      sh_en_q <= sh_en_d;
    end
  end
  // Num is held through the blank phase so the decoder has settled before the anode turns on
  always_comb begin
    blank = cnt_q < CW'(BLANK_CYCLES);
    Num = sh_dig_q[4*idx_q +: 4];
    Anode = '1;
    if (!blank) Anode[idx_q] = ~sh_en_q[idx_q];
    DP_n = blank ? 1'b1 : ~(sh_dp_q[idx_q] & sh_en_q[idx_q]);
    digit_idx = idx_q;
    frame_done = fd;
  end
endmodule

// File: tb/tb_sseg_scan_controller.sv
// tb_sseg_scan_controller: directed vectors; a cycle model queues expected outputs that a monitor checks,
// plus hand-computed spot checks of slot timing, buffering and reset.
module tb_sseg_scan_controller;
  logic clk = 0, reset = 1, load = 0;
  logic [15:0] digits = 0;
  logic [3:0] dp_mask = 0, digit_en = 0;
  logic [3:0] Num, Anode;
  logic DP_n, frame_done;
  logic [1:0] digit_idx;
  int checks = 0, errors = 0, nf = 0;
  typedef struct packed {logic [3:0] an; logic [3:0] num; logic dpn; logic [1:0] idx; logic fd;} obs_t;
  obs_t sb[$];
  sseg_scan_controller #(.NUM_DIGITS(4), .DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .digits(digits), .dp_mask(dp_mask), .digit_en(digit_en),
    .Num(Num), .Anode(Anode), .DP_n(DP_n), .digit_idx(digit_idx), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  // Expected outputs from absolute frame position t (0..31) and the shadow value the bench believes is live
  int t = 0, s, c;
  logic [15:0] sd = 0, pd = 0;
  logic [3:0] sp = 0, se = 0, pp = 0, pe = 0;
  logic pv = 0;
  obs_t me, oe, oa;
  initial forever begin
    @(posedge clk);
    if (reset) begin
      t = 0; sd = 0; sp = 0; se = 0; pd = 0; pp = 0; pe = 0; pv = 0;
    end else begin
      if (t == 31) begin
        if (load) {sd, sp, se} = {digits, dp_mask, digit_en};
        else if (pv) {sd, sp, se} = {pd, pp, pe};
        pv = 0;
      end else if (load) begin
        {pd, pp, pe} = {digits, dp_mask, digit_en};
        pv = 1;
      end
      t = (t + 1) % 32;
    end
    s = t / 8;
    c = t % 8;
    me.num = sd[4*s +: 4];
    me.an = 4'b1111;
    if (c >= 2 && se[s]) me.an[s] = 1'b0;
    me.dpn = !(c >= 2 && se[s] && sp[s]);
    me.idx = 2'(s);
    me.fd = (t == 31);
    sb.push_back(me);
  end
  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) begin
      oe = sb.pop_front();
      oa = {Anode, Num, DP_n, digit_idx, frame_done};
      checks++;
      if (oa !== oe) begin
        errors++;
        if (nf < 20) $display("FAIL scoreboard at %0t got an=%b num=%h dpn=%b idx=%0d fd=%b want an=%b num=%h dpn=%b idx=%0d fd=%b",
          $time, oa.an, oa.num, oa.dpn, oa.idx, oa.fd, oe.an, oe.num, oe.dpn, oe.idx, oe.fd);
        nf++;
      end
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_load(logic [15:0] d, logic [3:0] dp, logic [3:0] en);
    digits = d; dp_mask = dp; digit_en = en; load = 1;
    tick(1);
    load = 0;
  endtask
  task automatic wait_fd();
    int n = 0;
    do begin tick(1); n++; end while (!frame_done && n < 40);
    chk("wait_frame_done", frame_done, 1);
  endtask
  int fdc, n;
  logic ok, bad;
  initial begin
    tick(3);
    reset = 0;
    fdc = 0;
    repeat (64) begin tick(1); fdc += int'(frame_done); end
    chk("idle_fd_count", fdc, 2);
    chk("idle_anode", Anode, 4'hf);
    do_load(16'h1234, 4'b0100, 4'b1111);
    wait_fd();
    tick(1);
    chk("s0c0_anode", Anode, 4'b1111); chk("s0c0_num", Num, 4'h4); chk("s0c0_idx", digit_idx, 0);
    tick(2);
    chk("s0c2_anode", Anode, 4'b1110); chk("s0c2_dpn", DP_n, 1);
    tick(8);
    chk("s1_num", Num, 4'h3); chk("s1_anode", Anode, 4'b1101);
    tick(8);
    chk("s2_num", Num, 4'h2); chk("s2_anode", Anode, 4'b1011); chk("s2_dpn", DP_n, 0);
    tick(8);
    chk("s3_num", Num, 4'h1); chk("s3_anode", Anode, 4'b0111); chk("s3_idx", digit_idx, 3);
    do_load(16'h5678, 4'b1111, 4'b0101);
    wait_fd();
    ok = 1;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (!Anode[1] || !Anode[3] || (digit_idx[0] && !DP_n)) ok = 0;
      if (i == 2 && (Anode != 4'b1110 || DP_n)) ok = 0;
    end
    chk("en_masked", ok, 1);
    chk("en_timing", frame_done, 1);
    tick(1);
    do_load(16'h1111, 4'b0000, 4'b1111);
    tick(3);
    do_load(16'h2222, 4'b0000, 4'b1111);
    bad = 0; n = 0;
    do begin tick(1); n++; if (Num == 4'h1) bad = 1; end while (!frame_done && n < 40);
    chk("reach_fd_after_loads", frame_done, 1);
    ok = 1;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (Num == 4'h1) bad = 1;
      if (Num != 4'h2) ok = 0;
    end
    chk("no_stale_1", bad, 0);
    chk("all_2", ok, 1);
    chk("fd_before_abcd", frame_done, 1);
    do_load(16'hABCD, 4'b0000, 4'b1111);
    chk("abcd_num", Num, 4'hD); chk("abcd_idx", digit_idx, 0); chk("abcd_blank", Anode, 4'b1111);
    tick(2);
    chk("abcd_show", Anode, 4'b1110);
    tick(19);
    chk("pre_rst_idx", digit_idx, 2); chk("pre_rst_anode", Anode, 4'b1011); chk("pre_rst_num", Num, 4'hB);
    reset = 1; load = 1; digits = 16'h9999; digit_en = 4'hf; dp_mask = 4'hf;
    tick(1);
    reset = 0; load = 0;
    chk("rst_anode", Anode, 4'hf); chk("rst_num", Num, 0); chk("rst_idx", digit_idx, 0);
    chk("rst_dpn", DP_n, 1); chk("rst_fd", frame_done, 0);
    n = 0;
    do begin tick(1); n++; end while (!frame_done && n < 40);
    chk("post_rst_fd_cycles", n, 31);
    tick(32);
    chk("post_rst_dark", Anode, 4'hf);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
